// File: rtl/dlx_register_file_if.sv
// Bus between the DLX pipeline and its general-purpose register file.
// master = pipeline side (write-back plus decode operand selects)
// slave  = register file
interface dlx_register_file_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic              writenable;
   logic [ADDR_W-1:0] writesel;
   logic [DATA_W-1:0] Din;
   logic [ADDR_W-1:0] rs1_sel;
   logic [ADDR_W-1:0] rs2_sel;
   logic [DATA_W-1:0] rs1_out;
   logic [DATA_W-1:0] rs2_out;

   modport master (
      output writenable, writesel, Din, rs1_sel, rs2_sel,
      input  rs1_out, rs2_out
   );

   modport slave (
      input  writenable, writesel, Din, rs1_sel, rs2_sel,
      output rs1_out, rs2_out
   );
endinterface

// File: rtl/dlx_register_file.sv
// DLX general-purpose register file: 2**ADDR_W registers of DATA_W bits,
// two combinational read ports, one synchronous write port. R0 reads as
// zero. With BYPASS=1, a pending write is forwarded to any read port that
// selects the destination, so decode sees the write-back value in the
// same cycle.
module dlx_register_file #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int BYPASS = 1
) (
   input logic                 clk,
   input logic                 rst,
   dlx_register_file_if.slave  bus
);

   localparam int NREG = 2 ** ADDR_W;

   // Storage. Reads are combinational, so this maps to distributed
   // logic rather than a registered-read block RAM.
   logic [DATA_W-1:0] mem_reg [NREG];

   // A write that will actually land on the next edge: enabled, not
   // aimed at R0, and not overridden by reset.
   logic wr_hit;
   assign wr_hit = bus.writenable && (bus.writesel != '0) && !rst;

   // Register update: reset clears everything and beats a same-cycle write.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            mem_reg[i] <= '0;
         end
      end else if (wr_hit) begin
         mem_reg[bus.writesel] <= bus.Din;
      end
   end

   // Read ports 0 (rs1) and 1 (rs2) share identical logic.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_rd
         logic [ADDR_W-1:0] sel;
         logic [DATA_W-1:0] data;

         assign sel = (gi == 0) ? bus.rs1_sel : bus.rs2_sel;

         // R0 is forced to zero; otherwise forward a matching pending
         // write when bypass is enabled, else return stored contents.
         always_comb begin
            data = mem_reg[sel];
            if (sel == '0) begin
               data = '0;
            end else if ((BYPASS != 0) && wr_hit && (sel == bus.writesel)) begin
               data = bus.Din;
            end
         end
      end
   endgenerate

   assign bus.rs1_out = g_rd[0].data;
   assign bus.rs2_out = g_rd[1].data;

endmodule

// File: tb/tb_dlx_register_file.sv
// Self-checking bench for dlx_register_file (BYPASS=1). Stimulus pushes
// expected read-port values into a scoreboard and raises a probe strobe;
// a separate monitor pops and compares against the live outputs.
module tb_dlx_register_file;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   typedef struct {
      string       name;
      logic [31:0] e1;
      logic [31:0] e2;
   } exp_t;

   logic clk;
   logic rst;
   logic probe;
   int   checks;
   int   errors;
   exp_t sb[$];

   dlx_register_file_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   dlx_register_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: on each probe, compare both ports against the oldest expectation.
   initial begin
      checks = 0;
      errors = 0;
      forever begin
         @(posedge probe);
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: probe with no expectation queued");
         end else begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (bus.rs1_out !== e.e1) begin
               errors++;
               $display("FAIL %s rs1: got %08h expected %08h", e.name, bus.rs1_out, e.e1);
            end
            checks++;
            if (bus.rs2_out !== e.e2) begin
               errors++;
               $display("FAIL %s rs2: got %08h expected %08h", e.name, bus.rs2_out, e.e2);
            end
            $display("check %-12s rs1_sel=%0d rs1=%08h rs2_sel=%0d rs2=%08h",
                     e.name, bus.rs1_sel, bus.rs1_out, bus.rs2_sel, bus.rs2_out);
         end
      end
   end

   // Queue an expectation and strobe the monitor; called in the low clock phase.
   task automatic expect_now(input string name, input logic [31:0] e1, input logic [31:0] e2);
      exp_t e;
      #1;
      e.name = name;
      e.e1   = e1;
      e.e2   = e2;
      sb.push_back(e);
      probe = 1'b1;
      #1;
      probe = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic we, input logic [4:0] ws, input logic [31:0] d,
                        input logic [4:0] s1, input logic [4:0] s2);
      bus.writenable = we;
      bus.writesel   = ws;
      bus.Din        = d;
      bus.rs1_sel    = s1;
      bus.rs2_sel    = s2;
   endtask

   function automatic logic [31:0] sweep_val(input int i);
      logic [31:0] v;
      v = 32'h01010101 * i;
      return (i == 0) ? 32'h0 : v;
   endfunction

   initial begin
      probe = 1'b0;
      rst   = 1'b1;
      drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
      @(negedge clk);
      tick();

      // Reset still asserted: a write attempt must not forward.
      drive(1'b1, 5'd7, 32'hDEADBEEF, 5'd7, 5'd0);
      expect_now("rst_nofwd", 32'h0, 32'h0);
      tick();
      rst = 1'b0;
      drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

      // Post-reset sweep.
      for (int i = 0; i < 32; i++) begin
         bus.rs1_sel = 5'(i);
         bus.rs2_sel = 5'(31 - i);
         expect_now("rst_sweep", 32'h0, 32'h0);
      end

      // Basic write/read.
      drive(1'b1, 5'd1, 32'h00008421, 5'd0, 5'd0);
      tick();
      drive(1'b0, 5'd0, 32'h0, 5'd1, 5'd31);
      expect_now("basic_wr", 32'h00008421, 32'h0);

      // R0 protection, including no forwarding to R0.
      drive(1'b1, 5'd0, 32'h00001248, 5'd1, 5'd0);
      expect_now("r0_prefwd", 32'h00008421, 32'h0);
      tick();
      drive(1'b0, 5'd0, 32'h0, 5'd1, 5'd0);
      expect_now("r0_protect", 32'h00008421, 32'h0);

      // Bypass.
      drive(1'b1, 5'd5, 32'hAAAA0000, 5'd0, 5'd0);
      tick();
      drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd1);
      expect_now("r5_stored", 32'hAAAA0000, 32'h00008421);
      drive(1'b1, 5'd5, 32'h12345678, 5'd5, 5'd5);
      expect_now("bypass_both", 32'h12345678, 32'h12345678);
      bus.rs2_sel = 5'd1;
      expect_now("bypass_one", 32'h12345678, 32'h00008421);
      bus.rs1_sel = 5'd1;
      bus.rs2_sel = 5'd5;
      expect_now("bypass_rs2", 32'h00008421, 32'h12345678);
      tick();
      drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
      expect_now("bypass_post", 32'h12345678, 32'h12345678);

      // Write disable: no forwarding and no update.
      drive(1'b0, 5'd3, 32'hFFFFFFFF, 5'd3, 5'd5);
      expect_now("wdis_pre", 32'h0, 32'h12345678);
      tick();
      expect_now("wdis_post", 32'h0, 32'h12345678);

      // Reset priority over write.
      rst = 1'b1;
      drive(1'b1, 5'd7, 32'hDEADBEEF, 5'd7, 5'd1);
      tick();
      rst = 1'b0;
      drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd1);
      expect_now("rst_prio", 32'h0, 32'h0);
      bus.rs1_sel = 5'd5;
      expect_now("rst_clr_r5", 32'h0, 32'h0);

      // Full sweep: write each register, checking forwarding as it goes.
      for (int i = 1; i < 32; i++) begin
         drive(1'b1, 5'(i), sweep_val(i), 5'(i), 5'(i - 1));
         expect_now("sweep_fwd", sweep_val(i), sweep_val(i - 1));
         tick();
      end
      bus.writenable = 1'b0;
      for (int i = 0; i < 32; i++) begin
         bus.rs1_sel = 5'(i);
         bus.rs2_sel = 5'(31 - i);
         expect_now("sweep_rd", sweep_val(i), sweep_val(31 - i));
      end

      // Drain the scoreboard with a bounded wait.
      for (int t = 0; t < 50 && sb.size() != 0; t++) begin
         #1;
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expectations left, expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
